// File: rtl/input_arbiter_if.sv
// Control bundle between the button/gamepad front end and the player controller.
// The slave modport is the arbiter's view; master is the upstream/bench view.
interface input_arbiter_if;
   logic       i_frame_tick;
   logic       i_btn_up;
   logic       i_btn_down;
   logic       i_pad_present;
   logic       i_pad_up;
   logic       i_pad_down;
   logic       i_pad_a;
   logic       i_pad_b;
   logic       i_pad_start;
   logic       o_up;
   logic       o_down;
   logic       o_up_pulse;
   logic       o_start_pulse;
   logic [1:0] o_source;
   logic [3:0] dbg_release_cnt;

   modport slave (
      input  i_frame_tick, i_btn_up, i_btn_down,
      input  i_pad_present, i_pad_up, i_pad_down, i_pad_a, i_pad_b, i_pad_start,
      output o_up, o_down, o_up_pulse, o_start_pulse, o_source, dbg_release_cnt
   );

   modport master (
      output i_frame_tick, i_btn_up, i_btn_down,
      output i_pad_present, i_pad_up, i_pad_down, i_pad_a, i_pad_b, i_pad_start,
      input  o_up, o_down, o_up_pulse, o_start_pulse, o_source, dbg_release_cnt
   );
endinterface

// File: rtl/input_arbiter.sv
// Locks onto the first-used input source (board buttons or SNES pad) and emits
// registered up/down levels plus jump/start pulses. Gamepad path: INPUT_ARB_GAMEPAD_EN.
module input_arbiter #(
   parameter int RELEASE_TICKS = 4
) (
   input logic             clk,
   input logic             rst,
   input_arbiter_if.slave  bus
);

   localparam logic [3:0] REL_TICKS = 4'(RELEASE_TICKS);

   // o_source is the state register itself, so the encoding is fixed.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUTTONS = 2'd1
`ifdef INPUT_ARB_GAMEPAD_EN
      ,
      ST_GAMEPAD = 2'd2
`endif
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       up_q;
   logic       down_q;
   logic       up_pulse_q;
   logic       start_pulse_q;
   logic       start_q;

   logic       btn_act;
   logic       locked_act;
   logic       up_d;
   logic       down_raw;
   logic       down_d;
   logic       start_d;

   assign btn_act = bus.i_btn_up | bus.i_btn_down;

`ifdef INPUT_ARB_GAMEPAD_EN
   logic pad_up;
   logic pad_down;
   logic pad_start;
   logic pad_act;

   // Every pad term is gated by presence so an unplugged pad reads as idle.
   assign pad_up    = bus.i_pad_present & (bus.i_pad_up | bus.i_pad_a | bus.i_pad_b);
   assign pad_down  = bus.i_pad_present & bus.i_pad_down;
   assign pad_start = bus.i_pad_present & bus.i_pad_start;
   assign pad_act   = pad_up | pad_down | pad_start;
`else
   logic unused_pad;

   assign unused_pad = ^{bus.i_pad_present, bus.i_pad_up, bus.i_pad_down,
                         bus.i_pad_a, bus.i_pad_b, bus.i_pad_start};
`endif

   always_comb begin
      state_d    = state_q;
      locked_act = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_act) begin
               state_d = ST_BUTTONS;
`ifdef INPUT_ARB_GAMEPAD_EN
            end else if (pad_act) begin
               state_d = ST_GAMEPAD;
`endif
            end
         end
         ST_BUTTONS: begin
            locked_act = btn_act;
            if (cnt_q == REL_TICKS) begin
               state_d = ST_IDLE;
            end
         end
`ifdef INPUT_ARB_GAMEPAD_EN
         ST_GAMEPAD: begin
            locked_act = pad_act;
            if (!bus.i_pad_present || (cnt_q == REL_TICKS)) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Activity on the locked source beats a coincident frame tick.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) || (state_q == ST_IDLE) || locked_act) begin
         cnt_d = 4'd0;
      end else if (bus.i_frame_tick && (cnt_q != REL_TICKS)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Outputs follow the source selected by the next state, so the lock and the
   // first output level appear on the same edge.
   always_comb begin
      up_d     = 1'b0;
      down_raw = 1'b0;
      start_d  = 1'b0;
      case (state_d)
         ST_BUTTONS: begin
            up_d     = bus.i_btn_up;
            down_raw = bus.i_btn_down;
            start_d  = bus.i_btn_up;
         end
`ifdef INPUT_ARB_GAMEPAD_EN
         ST_GAMEPAD: begin
            up_d     = pad_up;
            down_raw = pad_down;
            start_d  = pad_start | pad_up;
         end
`endif
         default: begin
            up_d     = 1'b0;
            down_raw = 1'b0;
            start_d  = 1'b0;
         end
      endcase
      down_d = down_raw & ~up_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         up_q          <= 1'b0;
         down_q        <= 1'b0;
         up_pulse_q    <= 1'b0;
         start_pulse_q <= 1'b0;
         start_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         up_q          <= up_d;
         down_q        <= down_d;
         up_pulse_q    <= up_d & ~up_q;
         start_pulse_q <= start_d & ~start_q;
         start_q       <= start_d;
      end
   end

   assign bus.o_up            = up_q;
   assign bus.o_down          = down_q;
   assign bus.o_up_pulse      = up_pulse_q;
   assign bus.o_start_pulse   = start_pulse_q;
   assign bus.o_source        = state_q;
   assign bus.dbg_release_cnt = cnt_q;

endmodule

// File: tb/tb_input_arbiter.sv
// Self-checking bench for input_arbiter: cycle-by-cycle vector table plus a
// hand-written hold/release sequence, compared through an expected queue.
module tb_input_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   input_arbiter_if bus ();

   input_arbiter #(.RELEASE_TICKS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic rst;
      logic tick;
      logic bu;
      logic bd;
      logic pp;
      logic pu;
      logic pdn;
      logic pa;
      logic pb;
      logic ps;
   } in_t;

   typedef struct {
      string      name;
      in_t        ins;
      logic [5:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   string      name_q[$];
   int         checks   = 0;
   int         failures = 0;

   function automatic in_t mk(bit r, bit tick, bit bu, bit bd, bit pp,
                              bit pu, bit pdn, bit pa, bit pb, bit ps);
      in_t v;
      v = '{rst: r, tick: tick, bu: bu, bd: bd, pp: pp,
            pu: pu, pdn: pdn, pa: pa, pb: pb, ps: ps};
      return v;
   endfunction

   // Expected word: {source[1:0], up, down, up_pulse, start_pulse}
   function automatic logic [5:0] ex(int src, bit up, bit dn, bit upp, bit stp);
      logic [1:0] s;
      s = 2'(src);
      return {s, up, dn, upp, stp};
   endfunction

   function automatic void add(string n, in_t i, logic [5:0] e);
      vec_t v;
      v.name = n;
      v.ins  = i;
      v.exp  = e;
      vecs.push_back(v);
   endfunction

   task automatic drive(input in_t v);
      rst               = v.rst;
      bus.i_frame_tick  = v.tick;
      bus.i_btn_up      = v.bu;
      bus.i_btn_down    = v.bd;
      bus.i_pad_present = v.pp;
      bus.i_pad_up      = v.pu;
      bus.i_pad_down    = v.pdn;
      bus.i_pad_a       = v.pa;
      bus.i_pad_b       = v.pb;
      bus.i_pad_start   = v.ps;
   endtask

   task automatic check_out();
      logic [5:0] e;
      logic [5:0] act;
      string      n;
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {bus.o_source, bus.o_up, bus.o_down, bus.o_up_pulse, bus.o_start_pulse};
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s: got {src,up,down,up_pulse,start_pulse}=%b expected %b", n, act, e);
      end
   endtask

   task automatic step(input string n, input in_t v, input logic [5:0] e);
      @(negedge clk);
      drive(v);
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      int n_ticks;
      drive(mk(1,0,0,0,0,0,0,0,0,0));

      // Button path, shared by both builds.
      add("reset",             mk(1,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
      add("idle_quiet",        mk(0,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
      add("btn_up_press",      mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,1,1));
      add("btn_up_hold",       mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,0,0));
      add("up_and_down",       mk(0,0,1,1,0,0,0,0,0,0), ex(1,1,0,0,0));
      add("down_after_up",     mk(0,0,0,1,0,0,0,0,0,0), ex(1,0,1,0,0));
      add("release",           mk(0,0,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));
      add("tick1",             mk(0,1,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));
      add("tick2",             mk(0,1,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));
      add("tick_with_down",    mk(0,1,0,1,0,0,0,0,0,0), ex(1,0,1,0,0));
      add("release2",          mk(0,0,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));
      for (int i = 0; i < 4; i++)
         add($sformatf("tick_run%0d", i + 1), mk(0,1,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));
      add("drop_with_press",   mk(0,0,1,0,0,0,0,0,0,0), ex(0,0,0,0,0));
      add("relock",            mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,1,1));
      add("reset_mid_press",   mk(1,0,1,0,0,0,0,0,0,0), ex(0,0,0,0,0));
      add("press_after_reset", mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,1,1));
      add("reset_again",       mk(1,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
`ifdef INPUT_ARB_GAMEPAD_EN
      add("pad_a_lock",        mk(0,0,0,0,1,0,0,1,0,0), ex(2,1,0,1,1));
      add("pad_ignores_btn",   mk(0,0,1,0,1,0,0,1,0,0), ex(2,1,0,0,0));
      add("btn_only_on_pad",   mk(0,0,1,0,1,0,0,0,0,0), ex(2,0,0,0,0));
      for (int i = 0; i < 4; i++)
         add($sformatf("pad_tick%0d", i + 1), mk(0,1,0,0,1,0,0,0,0,0), ex(2,0,0,0,0));
      add("pad_drop",          mk(0,0,0,0,1,0,0,0,0,0), ex(0,0,0,0,0));
      add("both_same_cycle",   mk(0,0,1,0,1,1,0,0,0,0), ex(1,1,0,1,1));
      add("reset_pad",         mk(1,0,0,0,1,0,0,0,0,0), ex(0,0,0,0,0));
      add("pad_down_lock",     mk(0,0,0,0,1,0,1,0,0,0), ex(2,0,1,0,0));
      add("pad_unplug",        mk(0,0,0,0,0,0,1,0,0,0), ex(0,0,0,0,0));
      add("pad_start",         mk(0,0,0,0,1,0,0,0,0,1), ex(2,0,0,0,1));
      add("pad_start_hold",    mk(0,0,0,0,1,0,0,0,0,1), ex(2,0,0,0,0));
      add("pad_b_with_start",  mk(0,0,0,0,1,0,0,0,1,1), ex(2,1,0,1,0));
      add("reset_end",         mk(1,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
`else
      add("pad_ignored_a",     mk(0,0,0,0,1,0,0,1,0,0), ex(0,0,0,0,0));
      add("pad_ignored_mix",   mk(0,0,0,0,1,1,1,0,1,1), ex(0,0,0,0,0));
      add("pad_ignored_tick",  mk(0,1,0,0,1,0,0,0,0,1), ex(0,0,0,0,0));
      add("btn_down_idle",     mk(0,0,0,1,1,1,0,0,0,0), ex(1,0,1,0,0));
      add("reset_end",         mk(1,0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
`endif

      foreach (vecs[i])
         step(vecs[i].name, vecs[i].ins, vecs[i].exp);

      // Long hold: one pulse, then a steady level with no repeats.
      step("hold_press", mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,1,1));
      for (int i = 0; i < 10; i++)
         step($sformatf("hold_%0d", i), mk(0,0,1,0,0,0,0,0,0,0), ex(1,1,0,0,0));
      step("hold_release", mk(0,0,0,0,0,0,0,0,0,0), ex(1,0,0,0,0));

      // Continuous ticks: four fill the counter, the lock drops one edge later.
      n_ticks = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         drive(mk(0,1,0,0,0,0,0,0,0,0));
         @(posedge clk);
         #1;
         n_ticks = i;
         if (bus.o_source == 2'd0) break;
      end
      checks++;
      if ((n_ticks != 5) || (bus.o_source != 2'd0)) begin
         failures++;
         $display("FAIL drop_latency: got ticks=%0d source=%0d expected ticks=5 source=0",
                  n_ticks, bus.o_source);
      end

      @(negedge clk);
      drive(mk(0,0,0,0,0,0,0,0,0,0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
